// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encoding and fixed-point helpers for accelerator blocks
// Purpose : FSM state enum, Q8.8 fraction width, saturate/ReLU helper.
// Ports   : none (package).
package acc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    DRAIN,
    DONE
  } accState_t;

  localparam int FRAC_BITS = 8;

  // Clamps an already-shifted accumulator value into a signed dw-bit word.
  // The value is carried as 64-bit signed so any accumulator width fits.
  function automatic logic signed [63:0] satRelu(input logic signed [63:0] v,
                                                 input int dw,
                                                 input logic relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end else begin
      r = v;
    end
    if (relu && (r < 64'sd0)) begin
      r = 64'sd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_mac.sv
// rtl/acc_mac.sv - signed Q8.8 multiply-accumulate with saturated result register
// Purpose : multiplies a*b, loads or accumulates, shifts out the fraction and
//           saturates (optionally ReLU) into a registered result word.
// Ports   : clk, rst (async, active-high)
//           valid        - a/b carry a term this cycle
//           first        - term starts a new dot product (load instead of add)
//           a, b         - signed DW-bit operands
//           result       - saturated value of the accumulator including this term
//           result_valid - result was updated on the last edge
module acc_mac
  import acc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int N_IN = 8,
  parameter bit RELU = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic          first,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          result_valid
);

  localparam int ACCW = 2 * DW + $clog2(N_IN);

  logic signed [2*DW-1:0] aExt;
  logic signed [2*DW-1:0] bExt;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prodExt;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] accNext;
  logic signed [ACCW-1:0] accShift;
  logic signed [63:0]     accWide;

  always_comb begin
    aExt     = {{DW{a[DW-1]}}, a};
    bExt     = {{DW{b[DW-1]}}, b};
    prod     = aExt * bExt;
    prodExt  = {{(ACCW - 2 * DW){prod[2*DW-1]}}, prod};
    accNext  = first ? prodExt : acc + prodExt;
    accShift = accNext >>> FRAC_BITS;
    accWide  = {{(64 - ACCW){accShift[ACCW-1]}}, accShift};
  end

  // The result is taken from accNext, not acc, so the final sum of a row is
  // available on the same edge that absorbs its last term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= valid;
      if (valid) begin
        acc    <= accNext;
        result <= DW'(satRelu(accWide, DW, RELU));
      end
    end
  end

endmodule

// File: rtl/acc_layer_ctrl.sv
// rtl/acc_layer_ctrl.sv - fully-connected layer engine behind the CPU accelerator handshake
// Purpose : on iACC_en loads the input vector, streams the weight matrix through
//           acc_mac, writes saturated outputs, then holds done until en drops.
// Ports   : clk, rst (async, active-high)
//           iACC_en            - start/hold request from the CPU
//           oACC_done, oBusy   - job status
//           oMemRd, oRdAddr    - read port; iMemData valid one cycle after oMemRd
//           oMemWr, oWrAddr,
//           oWrData            - single-cycle write port
module acc_layer_ctrl
  import acc_pkg::*;
#(
  parameter int            N_IN     = 8,
  parameter int            N_OUT    = 4,
  parameter int            DW       = 16,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] IN_BASE  = 8'h40,
  parameter logic [AW-1:0] W_BASE   = 8'h80,
  parameter logic [AW-1:0] OUT_BASE = 8'h60,
  parameter int            RELU     = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iACC_en,
  output logic          oACC_done,
  output logic          oBusy,
  output logic          oMemRd,
  output logic [AW-1:0] oRdAddr,
  input  logic [DW-1:0] iMemData,
  output logic          oMemWr,
  output logic [AW-1:0] oWrAddr,
  output logic [DW-1:0] oWrData
);

  localparam int IW = $clog2(N_IN);
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  accState_t     state;
  accState_t     stateNext;
  logic          rdNext;
  logic [AW-1:0] rdAddrNext;
  logic [IW-1:0] iCnt;
  logic [IW-1:0] iNext;
  logic [JW-1:0] jCnt;
  logic [JW-1:0] jNext;
  logic [JW-1:0] wrRow;
  logic [DW-1:0] inBuf [N_IN];

  // Tags for the read issued last cycle, aligned with iMemData this cycle.
  logic          pendLoad;
  logic          pendMac;
  logic          pendFirst;
  logic          pendLast;
  logic [IW-1:0] pendIdx;
  logic          macResultValid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    rdNext     = 1'b0;
    rdAddrNext = oRdAddr;
    iNext      = iCnt;
    jNext      = jCnt;
    unique case (state)
      IDLE: begin
        if (iACC_en) begin
          stateNext  = LOAD;
          rdNext     = 1'b1;
          rdAddrNext = IN_BASE;
          iNext      = '0;
          jNext      = '0;
        end
      end
      LOAD: begin
        rdNext = 1'b1;
        if (iCnt == IW'(N_IN - 1)) begin
          stateNext  = MAC;
          rdAddrNext = W_BASE;
          iNext      = '0;
        end else begin
          rdAddrNext = oRdAddr + AW'(1);
          iNext      = iCnt + IW'(1);
        end
      end
      MAC: begin
        if ((iCnt == IW'(N_IN - 1)) && (jCnt == JW'(N_OUT - 1))) begin
          stateNext = DRAIN;
        end else begin
          rdNext     = 1'b1;
          rdAddrNext = oRdAddr + AW'(1);
          if (iCnt == IW'(N_IN - 1)) begin
            iNext = '0;
            jNext = jCnt + JW'(1);
          end else begin
            iNext = iCnt + IW'(1);
          end
        end
      end
      // The final row's write is the last bus activity of a job; leave as
      // soon as it is on the bus.
      DRAIN: begin
        if (oMemWr && macResultValid) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (!iACC_en) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oMemRd    <= 1'b0;
      oRdAddr   <= '0;
      oBusy     <= 1'b0;
      oACC_done <= 1'b0;
      oMemWr    <= 1'b0;
      oWrAddr   <= '0;
      iCnt      <= '0;
      jCnt      <= '0;
      wrRow     <= '0;
      pendLoad  <= 1'b0;
      pendMac   <= 1'b0;
      pendFirst <= 1'b0;
      pendLast  <= 1'b0;
      pendIdx   <= '0;
      for (int k = 0; k < N_IN; k++) begin
        inBuf[k] <= '0;
      end
    end else begin
      oMemRd    <= rdNext;
      oRdAddr   <= rdAddrNext;
      iCnt      <= iNext;
      jCnt      <= jNext;
      oBusy     <= (stateNext == LOAD) || (stateNext == MAC) || (stateNext == DRAIN);
      oACC_done <= (stateNext == DONE);
      pendLoad  <= (state == LOAD);
      pendMac   <= (state == MAC);
      pendIdx   <= iCnt;
      pendFirst <= (iCnt == '0);
      pendLast  <= (iCnt == IW'(N_IN - 1));
      if (pendLoad) begin
        inBuf[pendIdx] <= iMemData;
      end
      oMemWr <= pendMac && pendLast;
      if (pendMac && pendLast) begin
        oWrAddr <= OUT_BASE + AW'(wrRow);
        wrRow   <= wrRow + JW'(1);
      end
      if (state == IDLE) begin
        wrRow <= '0;
      end
    end
  end

  acc_mac #(
    .DW  (DW),
    .N_IN(N_IN),
    .RELU(RELU != 0)
  ) uMac (
    .clk         (clk),
    .rst         (rst),
    .valid       (pendMac),
    .first       (pendFirst),
    .a           (iMemData),
    .b           (inBuf[pendIdx]),
    .result      (oWrData),
    .result_valid(macResultValid)
  );

endmodule

// File: tb/tb_acc_layer_ctrl.sv
// tb/tb_acc_layer_ctrl.sv - scoreboard bench for acc_layer_ctrl (RELU=0 and RELU=1 instances)
module tb_acc_layer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] rdData = 16'h0000;

  logic        done0, busy0, rd0, wr0;
  logic [7:0]  rdAddr0, wrAddr0;
  logic [15:0] wrData0;
  logic        done1, busy1, rd1, wr1;
  logic [7:0]  rdAddr1, wrAddr1;
  logic [15:0] wrData1;

  logic [15:0] mem [256];
  int          cyc = 0;
  int          base = 0;
  int          checks = 0;
  int          errors = 0;
  int          activity;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wrExp_t;

  wrExp_t q0[$];
  wrExp_t q1[$];

  acc_layer_ctrl dut0 (
    .clk(clk), .rst(rst), .iACC_en(en), .oACC_done(done0), .oBusy(busy0),
    .oMemRd(rd0), .oRdAddr(rdAddr0), .iMemData(rdData), .oMemWr(wr0),
    .oWrAddr(wrAddr0), .oWrData(wrData0)
  );

  acc_layer_ctrl #(.RELU(1)) dut1 (
    .clk(clk), .rst(rst), .iACC_en(en), .oACC_done(done1), .oBusy(busy1),
    .oMemRd(rd1), .oRdAddr(rdAddr1), .iMemData(rdData), .oMemWr(wr1),
    .oWrAddr(wrAddr1), .oWrData(wrData1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0) rdData <= mem[rdAddr0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] expOut(input int j, input bit relu);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      acc += longint'($signed(mem[64 + i])) * longint'($signed(mem[128 + j * 8 + i]));
    end
    r = acc >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && (r < 0)) r = 0;
    return r[15:0];
  endfunction

  always @(negedge clk) begin
    wrExp_t e;
    if (wr0) begin
      if (q0.size() == 0) check("wr0_unexpected", wrAddr0, 8'hFF);
      else begin
        e = q0.pop_front();
        check("wr0_addr", wrAddr0, e.addr);
        check("wr0_data", wrData0, e.data);
        check("wr0_cycle", cyc, e.cyc);
      end
    end
    if (wr1) begin
      if (q1.size() == 0) check("wr1_unexpected", wrAddr1, 8'hFF);
      else begin
        e = q1.pop_front();
        check("wr1_addr", wrAddr1, e.addr);
        check("wr1_data", wrData1, e.data);
        check("wr1_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic loadConst(input logic [15:0] inV, input logic [15:0] wV);
    for (int i = 0; i < 8; i++) mem[64 + i] = inV;
    for (int m = 0; m < 32; m++) mem[128 + m] = wV;
  endtask

  task automatic loadRand();
    for (int i = 0; i < 8; i++) mem[64 + i] = 16'($urandom_range(0, 4095) - 2048);
    for (int m = 0; m < 32; m++) mem[128 + m] = 16'($urandom_range(0, 1023) - 512);
  endtask

  // Negative expected value means "use the model for this instance".
  task automatic startJob(input int e0, input int e1);
    wrExp_t e;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    base = cyc;
    for (int j = 0; j < 4; j++) begin
      e.addr = 8'(8'h60 + j);
      e.cyc = base + 8 * j + 18;
      e.data = (e0 < 0) ? expOut(j, 1'b0) : 16'(e0);
      q0.push_back(e);
      e.data = (e1 < 0) ? expOut(j, 1'b1) : 16'(e1);
      q1.push_back(e);
    end
  endtask

  task automatic waitJob(input int lastC, input int dropAt);
    for (int c = 1; c <= lastC; c++) begin
      @(negedge clk);
      check($sformatf("rd@%0d", c), rd0, c <= 40);
      check($sformatf("rd_relu@%0d", c), rd1, c <= 40);
      check($sformatf("busy@%0d", c), busy0, c <= 42);
      check($sformatf("done@%0d", c), done0, c == 43);
      if (c <= 8) check($sformatf("rdAddr@%0d", c), rdAddr0, 8'h40 + c - 1);
      else if (c <= 40) check($sformatf("rdAddr@%0d", c), rdAddr0, 8'h80 + c - 9);
      if (c == dropAt) en = 1'b0;
    end
  endtask

  task automatic finishJob();
    en = 1'b0;
    @(negedge clk);
    check("done_fall", done0, 1'b0);
    check("done_fall_relu", done1, 1'b0);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_done"}, done0, 1'b0);
    check({tag, "_busy"}, busy0, 1'b0);
    check({tag, "_rd"}, rd0, 1'b0);
    check({tag, "_rdAddr"}, rdAddr0, 8'h00);
    check({tag, "_wr"}, wr0, 1'b0);
    check({tag, "_wrAddr"}, wrAddr0, 8'h00);
    check({tag, "_wrData"}, wrData0, 16'h0000);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    repeat (3) @(negedge clk);
    checkZero("reset");
    rst = 1'b0;

    activity = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd0 || busy0 || wr0) activity++;
    end
    check("idle_activity", activity, 0);
    rst = 1'b1;
    #1;
    checkZero("idle_reset");
    @(negedge clk);
    rst = 1'b0;

    loadConst(16'h0100, 16'h0080);
    startJob(16'h0400, 16'h0400);
    waitJob(43, 0);
    repeat (20) begin
      @(negedge clk);
      check("hold_done", done0, 1'b1);
      check("hold_rd", rd0, 1'b0);
      check("hold_busy", busy0, 1'b0);
    end
    finishJob();
    startJob(16'h0400, 16'h0400);
    waitJob(43, 0);
    finishJob();

    loadConst(16'h7FFF, 16'h7FFF);
    startJob(16'h7FFF, 16'h7FFF);
    waitJob(43, 0);
    finishJob();

    loadConst(16'h8000, 16'h7FFF);
    startJob(16'h8000, 16'h0000);
    waitJob(43, 20);
    finishJob();

    loadConst(16'h0200, 16'hFF00);
    startJob(16'hF000, 16'h0000);
    waitJob(43, 0);
    finishJob();

    loadRand();
    startJob(-1, -1);
    waitJob(43, 0);
    finishJob();

    loadRand();
    startJob(-1, -1);
    waitJob(24, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkZero("midjob_reset");
    check("midjob_q0_left", q0.size(), 3);
    check("midjob_q1_left", q1.size(), 3);
    q0.delete();
    q1.delete();
    repeat (3) @(negedge clk);
    checkZero("midjob_hold");
    startJob(-1, -1);
    waitJob(43, 0);
    finishJob();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
